// File: rtl/clock_cmd_scheduler_if.sv
// Command-path bundle between the raw button/tick inputs and the time counter.
// The slave side is the scheduler; the master side drives buttons, tick and op_done.
interface clock_cmd_scheduler_if;
  logic [2:0] btn;
  logic       tick_1hz;
  logic       op_done;
  logic [1:0] operate;
  logic       op_valid;
  logic       busy;
  logic       timeout_err;

  modport master (
    output btn, tick_1hz, op_done,
    input  operate, op_valid, busy, timeout_err
  );

  modport slave (
    input  btn, tick_1hz, op_done,
    output operate, op_valid, busy, timeout_err
  );
endinterface

// File: rtl/clock_cmd_scheduler.sv
// Button front end for the clock's time-set path: sync, debounce, sticky requests,
// fixed-priority issue of one operate command at a time, kept off 1 Hz tick cycles.
module clock_cmd_scheduler #(
  parameter int DB_CYCLES     = 250000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  clock_cmd_scheduler_if.slave  bus
);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int RPW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam int TOW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DBW-1:0] DB_LAST     = DBW'(DB_CYCLES - 1);
  localparam logic [RPW-1:0] DELAY_LAST  = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] PERIOD_LAST = RPW'(REPEAT_PERIOD - 1);
  localparam logic [TOW-1:0] TO_LAST     = TOW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MIN  = 2'b10;
  localparam logic [1:0] OP_SEC  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    GAP  = 2'b10
  } state_t;

  logic [2:0]     sync1_r;
  logic [2:0]     sync2_r;
  logic [2:0]     deb_r;
  logic [2:0]     deb_d_r;
  logic [2:0]     pending_r;
  logic [DBW-1:0] db_cnt_r [3];
  logic [RPW-1:0] rep_cnt_r;
  logic           rep_armed_r;
  logic [TOW-1:0] to_cnt_r;
  state_t         state_r;
  state_t         state_s;
  logic [1:0]     operate_r;
  logic [1:0]     operate_s;
  logic           op_valid_r;
  logic           op_valid_s;
  logic           busy_r;
  logic           timeout_err_r;
  logic           timeout_set_s;
  logic [2:0]     set_s;
  logic [2:0]     clr_s;
  logic           rep_held_s;
  logic           rep_fire_s;

  // Two-flop synchroniser and per-bit debounce counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      deb_r   <= 3'b000;
      deb_d_r <= 3'b000;
      for (int b = 0; b < 3; b++) begin
        db_cnt_r[b] <= '0;
      end
    end else begin
      sync1_r <= bus.btn;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      for (int b = 0; b < 3; b++) begin
        if (sync2_r[b] == deb_r[b]) begin
          db_cnt_r[b] <= '0;
        end else if (db_cnt_r[b] == DB_LAST) begin
          deb_r[b]    <= sync2_r[b];
          db_cnt_r[b] <= '0;
        end else begin
          db_cnt_r[b] <= db_cnt_r[b] + DBW'(1);
        end
      end
    end
  end

  // Holding starts the cycle after the edge that raised the minute_add request,
  // so the first repeat lands REPEAT_DELAY cycles after the initial request.
  assign rep_held_s = deb_r[2] & deb_d_r[2];
  assign rep_fire_s = rep_held_s &
                      (rep_armed_r ? (rep_cnt_r == PERIOD_LAST) : (rep_cnt_r == DELAY_LAST));
  assign set_s      = {(deb_r[2] & ~deb_d_r[2]) | rep_fire_s, deb_r[1:0] & ~deb_d_r[1:0]};

  // Auto-repeat counter: initial delay phase, then periodic phase.
  always_ff @(posedge clk) begin
    if (reset || !rep_held_s) begin
      rep_cnt_r   <= '0;
      rep_armed_r <= 1'b0;
    end else if (rep_fire_s) begin
      rep_cnt_r   <= '0;
      rep_armed_r <= 1'b1;
    end else begin
      rep_cnt_r   <= rep_cnt_r + RPW'(1);
      rep_armed_r <= rep_armed_r;
    end
  end

  // Acknowledge timeout counter, only meaningful while waiting.
  always_ff @(posedge clk) begin
    if (reset || (state_r != WAIT)) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TOW'(1);
    end
  end

  // Next-state and command selection.
  always_comb begin
    state_s       = state_r;
    operate_s     = operate_r;
    op_valid_s    = op_valid_r;
    clr_s         = 3'b000;
    timeout_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if ((pending_r != 3'b000) && !bus.tick_1hz) begin
          op_valid_s = 1'b1;
          state_s    = WAIT;
          if (pending_r[0]) begin
            operate_s = OP_CLR;
            clr_s     = 3'b111;
          end else if (pending_r[1]) begin
            operate_s = OP_SEC;
            clr_s     = 3'b010;
          end else begin
            operate_s = OP_MIN;
            clr_s     = 3'b100;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (bus.op_done) begin
          op_valid_s = 1'b0;
          operate_s  = OP_NONE;
          state_s    = GAP;
        end else if (to_cnt_r == TO_LAST) begin
          op_valid_s    = 1'b0;
          operate_s     = OP_NONE;
          timeout_set_s = 1'b1;
          state_s       = GAP;
        end else begin
          state_s = WAIT;
        end
      end
      GAP: begin
        state_s = IDLE;
      end
      default: begin
        state_s    = IDLE;
        operate_s  = OP_NONE;
        op_valid_s = 1'b0;
      end
    endcase
  end

  // State, pending requests and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      operate_r     <= OP_NONE;
      op_valid_r    <= 1'b0;
      pending_r     <= 3'b000;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      operate_r     <= operate_s;
      op_valid_r    <= op_valid_s;
      pending_r     <= (pending_r & ~clr_s) | set_s;
      busy_r        <= (state_r != IDLE) || (pending_r != 3'b000);
      timeout_err_r <= timeout_err_r | timeout_set_s;
    end
  end

  assign bus.operate     = operate_r;
  assign bus.op_valid    = op_valid_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = timeout_err_r;
endmodule
